edge_capture_fifo: RTL and testbench

Multi-channel, single-clock event sampler. A per-channel edge or level condition on a trigger input captures that channel's data word into a one-deep pending slot. A round-robin arbiter drains the pending slots into a shared FIFO, which is read through a valid/ready port. This block replaces netlist-level flops clocked by a derived condition signal with a fully synchronous capture path, and adds width, channel-count and mode generality plus overflow reporting.

---
 rtl/edge_capture_fifo.sv | 142 ++++++++++++++
 tb/tb_edge_capture_fifo.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_capture_fifo.sv
// edge_capture_fifo: multi-channel synchronous event sampler.
// Each channel captures its data word into a one-deep pending slot on an
// edge/level condition of its trigger. A round-robin arbiter moves pending
// samples into a shared FIFO, which is read through a valid/ready port.
module edge_capture_fifo #(
  parameter int W     = 1,
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic [N-1:0]             trig,
  input  logic [N*W-1:0]           data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic [$clog2(N)-1:0]     out_chan,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int CW = $clog2(N);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    MODE_RISE  = 2'b00,
    MODE_FALL  = 2'b01,
    MODE_BOTH  = 2'b10,
    MODE_LEVEL = 2'b11
  } mode_e;

  typedef struct packed {
    logic [CW-1:0] chan;
    logic [W-1:0]  data;
  } entry_t;

  logic [N-1:0]  trig_q;
  logic [N-1:0]  ev;
  logic [N-1:0]  drop;
  logic [N-1:0]  pend_v;
  logic [W-1:0]  pend_d [N];
  logic [CW-1:0] last_grant;
  logic          gnt_v;
  logic [CW-1:0] gnt_idx;
  logic          pop;
  logic          push;
  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  entry_t        head;

  // Per-channel event condition for the selected mode, gated by enable.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    ev = '0;
    case (mode_e'(mode))
      MODE_RISE: ev = trig & ~trig_q;
      MODE_FALL: ev = ~trig & trig_q;
      MODE_BOTH: ev = trig ^ trig_q;
      default:   ev = trig;
    endcase
    if (!en) ev = '0;
  end

  // Round-robin search for the first pending channel after last_grant.
  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = last_grant;
    for (int i = 1; i <= N; i++) begin
      if (!gnt_v && pend_v[(int'(last_grant) + i) % N]) begin
        gnt_v   = 1'b1;
        gnt_idx = CW'((int'(last_grant) + i) % N);
      end
    end
  end

  // A full FIFO still accepts a write in a cycle where the head is popped.
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = gnt_v & ((count < FULL) | pop);

  // A sample is lost when its slot is occupied and not being drained now.
  always_comb begin
    drop = '0;
    for (int c = 0; c < N; c++) begin
      drop[c] = ev[c] & pend_v[c] & ~(push && (gnt_idx == CW'(c)));
    end
  end

  // Control state: trigger history, slot flags, arbiter, FIFO pointers, flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_q     <= '0;
      pend_v     <= '0;
      last_grant <= CW'(N - 1);
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      trig_q <= trig;
      for (int c = 0; c < N; c++) begin
        if (push && (gnt_idx == CW'(c))) pend_v[c] <= ev[c];
        else if (ev[c])                  pend_v[c] <= 1'b1;
      end
      if (push) begin
        last_grant <= gnt_idx;
        wr_ptr     <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (|drop)        overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Datapath storage: slot data and FIFO entries, qualified by the flags above.
  always_ff @(posedge clk) begin
    // NOTE: data storage is deliberately not reset; validity is carried by
    // pend_v and count, which are reset, so stale contents are never visible.
    for (int c = 0; c < N; c++) begin
      if (ev[c] && !drop[c]) pend_d[c] <= data[c*W +: W];
    end
    if (push) mem[wr_ptr] <= '{chan: gnt_idx, data: pend_d[gnt_idx]};
  end

  assign head     = mem[rd_ptr];
  assign out_data = head.data;
  assign out_chan = head.chan;

endmodule

// File: tb/tb_edge_capture_fifo.sv
// Directed bench for edge_capture_fifo (W=8, N=4, DEPTH=4): a vector table
// for round-robin and single-edge behaviour, then hand sequences for the
// full/overflow, push-while-full, enable/mode and mid-operation reset cases.
module tb_edge_capture_fifo;

  localparam int W = 8;
  localparam int N = 4;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           en;
  logic [1:0]     mode;
  logic [N-1:0]   trig;
  logic [N*W-1:0] data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_chan;
  logic [2:0]     count;
  logic           overflow;
  logic           clr_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic           en;
    logic [1:0]     mode;
    logic [N-1:0]   trig;
    logic [N*W-1:0] data;
    logic           rdy;
    logic           exp_valid;
    logic [W-1:0]   exp_data;
    logic [1:0]     exp_chan;
    logic [2:0]     exp_count;
  } vec_t;

  vec_t vecs[$];

  edge_capture_fifo #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .mode      (mode),
    .trig      (trig),
    .data      (data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic v, input logic [2:0] c, input logic o);
    check({tag, " out_valid"}, 32'(out_valid), 32'(v));
    check({tag, " count"},     32'(count),     32'(c));
    check({tag, " overflow"},  32'(overflow),  32'(o));
  endtask

  task automatic chk_head(input string tag, input logic [W-1:0] d, input logic [1:0] ch);
    check({tag, " out_data"}, 32'(out_data), 32'(d));
    check({tag, " out_chan"}, 32'(out_chan), 32'(ch));
  endtask

  task automatic set_data(input int c, input logic [W-1:0] v);
    data[c*W +: W] = v;
  endtask

  function automatic vec_t mk(input logic e, input logic [1:0] m, input logic [N-1:0] t,
                              input logic [N*W-1:0] d, input logic r, input logic ev,
                              input logic [W-1:0] ed, input logic [1:0] ec,
                              input logic [2:0] ecnt);
    vec_t v;
    v.en = e; v.mode = m; v.trig = t; v.data = d; v.rdy = r;
    v.exp_valid = ev; v.exp_data = ed; v.exp_chan = ec; v.exp_count = ecnt;
    return v;
  endfunction

  initial begin
    // Reset with everything idle.
    reset_n = 1'b0; en = 1'b0; mode = 2'b00; trig = '0; data = '0;
    out_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Round-robin bursts (last_grant starts at 3), then a single rising edge.
    vecs.push_back(mk(1'b1, 2'b00, 4'h0, 32'h00000000, 1'b1, 1'b0, 8'h00, 2'd0, 3'd0));
    vecs.push_back(mk(1'b1, 2'b00, 4'hF, 32'h13121110, 1'b1, 1'b0, 8'h00, 2'd0, 3'd0));
    vecs.push_back(mk(1'b1, 2'b00, 4'hF, 32'h13121110, 1'b1, 1'b1, 8'h10, 2'd0, 3'd1));
    vecs.push_back(mk(1'b1, 2'b00, 4'hF, 32'h13121110, 1'b1, 1'b1, 8'h11, 2'd1, 3'd1));
    vecs.push_back(mk(1'b1, 2'b00, 4'hF, 32'h13121110, 1'b1, 1'b1, 8'h12, 2'd2, 3'd1));
    vecs.push_back(mk(1'b1, 2'b00, 4'hF, 32'h13121110, 1'b1, 1'b1, 8'h13, 2'd3, 3'd1));
    vecs.push_back(mk(1'b1, 2'b00, 4'hF, 32'h13121110, 1'b1, 1'b0, 8'h00, 2'd0, 3'd0));
    vecs.push_back(mk(1'b1, 2'b00, 4'h0, 32'h13121110, 1'b1, 1'b0, 8'h00, 2'd0, 3'd0));
    vecs.push_back(mk(1'b1, 2'b00, 4'hF, 32'h23222120, 1'b1, 1'b0, 8'h00, 2'd0, 3'd0));
    vecs.push_back(mk(1'b1, 2'b00, 4'hF, 32'h23222120, 1'b1, 1'b1, 8'h20, 2'd0, 3'd1));
    vecs.push_back(mk(1'b1, 2'b00, 4'hF, 32'h23222120, 1'b1, 1'b1, 8'h21, 2'd1, 3'd1));
    vecs.push_back(mk(1'b1, 2'b00, 4'hF, 32'h23222120, 1'b1, 1'b1, 8'h22, 2'd2, 3'd1));
    vecs.push_back(mk(1'b1, 2'b00, 4'hF, 32'h23222120, 1'b1, 1'b1, 8'h23, 2'd3, 3'd1));
    vecs.push_back(mk(1'b1, 2'b00, 4'hF, 32'h23222120, 1'b1, 1'b0, 8'h00, 2'd0, 3'd0));
    vecs.push_back(mk(1'b1, 2'b00, 4'h0, 32'h23222120, 1'b0, 1'b0, 8'h00, 2'd0, 3'd0));
    vecs.push_back(mk(1'b1, 2'b00, 4'h4, 32'h005A0000, 1'b0, 1'b0, 8'h00, 2'd0, 3'd0));
    vecs.push_back(mk(1'b1, 2'b00, 4'h4, 32'h005A0000, 1'b0, 1'b1, 8'h5A, 2'd2, 3'd1));
    vecs.push_back(mk(1'b1, 2'b00, 4'h4, 32'h005A0000, 1'b1, 1'b0, 8'h00, 2'd0, 3'd0));

    foreach (vecs[i]) begin
      en = vecs[i].en; mode = vecs[i].mode; trig = vecs[i].trig;
      data = vecs[i].data; out_ready = vecs[i].rdy;
      tick();
      chk_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_count, 1'b0);
      if (vecs[i].exp_valid) chk_head($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_chan);
    end

    // Full FIFO and overflow: channel 1 toggled six times in both-edge mode.
    out_ready = 1'b0; mode = 2'b00; trig = '0;
    tick();
    chk_state("full.pre", 1'b0, 3'd0, 1'b0);
    mode = 2'b10;
    for (int k = 1; k <= 6; k++) begin
      trig[1] = ~trig[1];
      set_data(1, 8'(8'hA0 + k));
      tick();
      if (k == 6) chk_state("full.drop", 1'b1, 3'd4, 1'b1);
      tick();
      chk_state($sformatf("full.s%0d", k), 1'b1, 3'((k > 4) ? 4 : k), (k == 6));
    end
    chk_head("full.head", 8'hA1, 2'd1);
    out_ready = 1'b1;
    for (int j = 2; j <= 5; j++) begin
      tick();
      chk_state($sformatf("drain.%0d", j), 1'b1, 3'((j == 2) ? 4 : 6 - j), 1'b1);
      chk_head($sformatf("drain.%0d", j), 8'(8'hA0 + j), 2'd1);
    end
    tick();
    chk_state("drain.empty", 1'b0, 3'd0, 1'b1);
    out_ready = 1'b0; clr_ovf = 1'b1;
    tick();
    chk_state("clr_ovf", 1'b0, 3'd0, 1'b0);
    clr_ovf = 1'b0;

    // Full FIFO with channel 0 pending; one cycle of simultaneous pop/push.
    for (int k = 1; k <= 5; k++) begin
      trig[0] = ~trig[0];
      set_data(0, 8'(8'hB0 + k));
      tick();
      tick();
    end
    chk_state("pp.full", 1'b1, 3'd4, 1'b0);
    chk_head("pp.full", 8'hB1, 2'd0);
    out_ready = 1'b1;
    tick();
    chk_state("pp.swap", 1'b1, 3'd4, 1'b0);
    chk_head("pp.swap", 8'hB2, 2'd0);
    out_ready = 1'b0;
    tick();
    chk_state("pp.hold", 1'b1, 3'd4, 1'b0);
    out_ready = 1'b1;
    for (int j = 3; j <= 5; j++) begin
      tick();
      chk_state($sformatf("pp.drain%0d", j), 1'b1, 3'(6 - j), 1'b0);
      chk_head($sformatf("pp.drain%0d", j), 8'(8'hB0 + j), 2'd0);
    end
    tick();
    chk_state("pp.empty", 1'b0, 3'd0, 1'b0);

    // Enable edge: trig[3] already high when en rises gives no event.
    en = 1'b0; mode = 2'b00; trig = 4'b1001;
    tick(); tick();
    chk_state("en.off", 1'b0, 3'd0, 1'b0);
    en = 1'b1;
    tick(); tick();
    chk_state("en.on", 1'b0, 3'd0, 1'b0);
    // Falling mode: dropping trig[3] gives exactly one entry.
    mode = 2'b01; trig = 4'b0001; set_data(3, 8'hC3);
    tick();
    chk_state("fall.e0", 1'b0, 3'd0, 1'b0);
    tick();
    chk_state("fall.e1", 1'b1, 3'd1, 1'b0);
    chk_head("fall.e1", 8'hC3, 2'd3);
    tick();
    chk_state("fall.pop", 1'b0, 3'd0, 1'b0);
    tick();
    chk_state("fall.once", 1'b0, 3'd0, 1'b0);
    // Level-high mode: trig[0] held gives one entry per cycle, no overflow.
    mode = 2'b11;
    for (int k = 0; k < 4; k++) begin
      set_data(0, 8'(8'hD0 + k));
      tick();
      if (k == 0) chk_state("lvl.0", 1'b0, 3'd0, 1'b0);
      else begin
        chk_state($sformatf("lvl.%0d", k), 1'b1, 3'd1, 1'b0);
        chk_head($sformatf("lvl.%0d", k), 8'(8'hD0 + k - 1), 2'd0);
      end
    end
    mode = 2'b00;
    tick();
    chk_state("lvl.tail", 1'b1, 3'd1, 1'b0);
    chk_head("lvl.tail", 8'hD3, 2'd0);
    tick();
    chk_state("lvl.empty", 1'b0, 3'd0, 1'b0);

    // Reset mid-operation: count=3, channels 0 and 1 pending, overflow set.
    out_ready = 1'b0; trig = 4'b0000;
    tick();
    mode = 2'b10; trig = 4'hF; data = 32'h43424140;
    tick();
    chk_state("mid.e1", 1'b0, 3'd0, 1'b0);
    trig = 4'b1101;
    tick();
    chk_state("mid.e2", 1'b1, 3'd1, 1'b0);
    chk_head("mid.e2", 8'h41, 2'd1);
    tick();
    chk_state("mid.e3", 1'b1, 3'd2, 1'b0);
    trig = 4'b1100;
    tick();
    chk_state("mid.e4", 1'b1, 3'd3, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_state("mid.rst", 1'b0, 3'd0, 1'b0);
    mode = 2'b00; trig = 4'b0010; set_data(1, 8'h77);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk_state("post.e0", 1'b0, 3'd0, 1'b0);
    tick();
    chk_state("post.e1", 1'b1, 3'd1, 1'b0);
    chk_head("post.e1", 8'h77, 2'd1);
    tick();
    chk_state("post.once", 1'b1, 3'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
